// File: rtl/count_display.sv
// Binary-to-BCD converter (sequential double-dabble) driving a multiplexed common-anode 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module count_display #(
  parameter int unsigned N           = 14,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  valid,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned BW  = 4 * DIGITS;
  localparam int unsigned CW  = $clog2(N + 1);
  localparam int unsigned SCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic longint unsigned pow10(input int unsigned d);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned LIMIT = pow10(DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t          state_q, state_d;
  logic            load, shift, commit;
  logic [N-1:0]    sr_q;
  logic [BW-1:0]   acc_q, acc_adj;
  logic [CW-1:0]   sh_cnt_q;
  logic            ovf_cmp_q;
  logic [BW-1:0]   bcd_q;
  logic            ovf_q, valid_q;
  logic [SCW-1:0]  scan_q;
  logic [IW-1:0]   idx_q;
  logic [3:0]      nib_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = SHIFT;
      SHIFT:   if (sh_cnt_q == CW'(N - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load   = (state_q == IDLE);
    shift  = (state_q == SHIFT);
    commit = (state_q == COMMIT);
  end

  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Carries out of the top nibble fall off the left end of the shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      acc_q     <= '0;
      sh_cnt_q  <= '0;
      ovf_cmp_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (load) begin
        sr_q      <= value;
        acc_q     <= '0;
        sh_cnt_q  <= '0;
        ovf_cmp_q <= (64'(value) >= LIMIT);
      end
      if (shift) begin
        {acc_q, sr_q} <= {acc_adj, sr_q} << 1;
        sh_cnt_q      <= sh_cnt_q + 1'b1;
      end
      if (commit) begin
        bcd_q   <= acc_q;
        ovf_q   <= ovf_cmp_q;
        valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SCW'(REFRESH_DIV - 1)) begin
      scan_q <= '0;
      idx_q  <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  always_comb begin
    an          = '1;
    an[idx_q]   = 1'b0;
    dp          = 1'b1;
    nib_sel     = bcd_q[4*idx_q +: 4];
    unique case (nib_sel)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_q != '0) && ((bcd_q >> (4*idx_q)) == '0)) seg = 7'b1111111;
`endif
    if (ovf_q) seg = 7'b0111111;
  end

  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_count_display.sv
// Directed, table-driven checks of count_display (N=14, DIGITS=4, REFRESH_DIV=4).
module tb_count_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] value = '0;
  logic [15:0] bcd;
  logic        overflow, valid;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  count_display #(.N(14), .DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .value(value), .bcd(bcd), .overflow(overflow),
    .valid(valid), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Edges since reset release; gives the expected scan position.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic [13:0] v;
    logic [15:0] b;
    logic        o;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] b, input logic o, input int k);
    logic [15:0] hi;
    if (o) return 7'b0111111;
    hi = b >> (4 * k);
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && hi == 16'h0) return 7'b1111111;
`endif
    return dec(hi[3:0]);
  endfunction

  task automatic check_scan(input logic [15:0] eb, input logic eo);
    int k;
    logic [3:0] ea;
    k = (cyc / 4) % 4;
    ea = 4'b1111;
    ea[k] = 1'b0;
    chk("an", {28'h0, an}, {28'h0, ea});
    chk("seg", {25'h0, seg}, {25'h0, exp_seg(eb, eo, k)});
    chk("dp", {31'h0, dp}, 32'h1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!valid && n < 40);
    if (!valid) begin
      n_vec++;
      n_fail++;
      $display("FAIL valid_timeout: got no valid within %0d cycles", n);
    end
  endtask

  // From reset release: valid first rises after exactly 16 edges.
  task automatic run_from_reset(input logic [15:0] eb);
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      chk("valid_timing", {31'h0, valid}, (e == 16) ? 32'h1 : 32'h0);
      chk("bcd_hold", {16'h0, bcd}, (e == 16) ? {16'h0, eb} : 32'h0);
      check_scan((e == 16) ? eb : 16'h0, 1'b0);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{14'd1234,  16'h1234, 1'b0};
    vecs[1] = '{14'd9999,  16'h9999, 1'b0};
    vecs[2] = '{14'd10000, 16'h0000, 1'b1};
    vecs[3] = '{14'd16383, 16'h6383, 1'b1};
    vecs[4] = '{14'd0,     16'h0000, 1'b0};
    vecs[5] = '{14'd7,     16'h0007, 1'b0};
    vecs[6] = '{14'd42,    16'h0042, 1'b0};
    vecs[7] = '{14'd99,    16'h0099, 1'b0};
    vecs[8] = '{14'd1000,  16'h1000, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_bcd", {16'h0, bcd}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_an", {28'h0, an}, 32'h0000000e);
    chk("rst_seg", {25'h0, seg}, 32'h00000040);
    run_from_reset(16'h0000);

    foreach (vecs[i]) begin
      value = vecs[i].v;
      wait_valid(n);
      wait_valid(n);
      chk("period", n, 16);
      chk("bcd", {16'h0, bcd}, {16'h0, vecs[i].b});
      chk("overflow", {31'h0, overflow}, {31'h0, vecs[i].o});
      repeat (16) begin
        @(posedge clk); #1;
        check_scan(vecs[i].b, vecs[i].o);
      end
    end

    // value changes mid-SHIFT: only the IDLE sample counts
    value = 14'd42;
    wait_valid(n);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1 value = 14'd7;
    wait_valid(n);
    chk("midshift_lat", n, 12);
    chk("midshift_bcd0", {16'h0, bcd}, 32'h42);
    wait_valid(n);
    chk("midshift_bcd1", {16'h0, bcd}, 32'h07);

    // reset 5 cycles into SHIFT aborts the conversion
    value = 14'd555;
    wait_valid(n);
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_bcd", {16'h0, bcd}, 32'h0);
    chk("abort_valid", {31'h0, valid}, 32'h0);
    chk("abort_an", {28'h0, an}, 32'h0000000e);
    chk("abort_seg", {25'h0, seg}, 32'h00000040);
    @(posedge clk);
    #1 rst = 1'b0;
    run_from_reset(16'h0555);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
